// File: rtl/fp_gen_pkg.sv
// Shared definitions for the fingerprint-vector stream generator.
//   state_t        : run-control FSM states
//   LFSR_POLY      : Galois feedback mask applied when the shifted-out bit is 1
//   LANE_SEED_K    : golden-ratio constant used to decorrelate lane seeds
//   beats_per_run(): bus beats needed to carry vec_total vectors
package fp_gen_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StFin
    } state_t;

    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam logic [31:0] LANE_SEED_K = 32'h9E37_79B9;

    function automatic int unsigned beats_per_run(input int unsigned vec_total,
                                                  input int unsigned vec_bytes,
                                                  input int unsigned bus_bytes);
        return (vec_total * vec_bytes + bus_bytes - 1) / bus_bytes;
    endfunction

endpackage

// File: rtl/fp_lfsr32.sv
// One 32-bit Galois LFSR lane (right-shifting form).
//   i_clk   : clock
//   i_rstn  : synchronous active-low reset, clears the state to 0
//   i_load  : load i_seed into the state
//   i_seed  : seed value (caller guarantees non-zero)
//   i_en    : advance one step
//   o_next  : the state one step ahead of the current state
module fp_lfsr32
    import fp_gen_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    input  logic        i_en,
    output logic [31:0] o_next
);

    logic [31:0] r_state;
    logic [31:0] w_next;

    // Shift right; the bit falling out of bit 0 selects the feedback mask.
    always_comb begin
        w_next = {1'b0, r_state[31:1]} ^ (r_state[0] ? LFSR_POLY : 32'h0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

    assign o_next = w_next;

endmodule

// File: rtl/fp_axis_vec_gen.sv
// AXI4-Stream fingerprint-vector source. On start, emits vec_total vectors of
// VECTOR_WIDTH_BYTES bytes packed back to back on a BUS_WIDTH bus, tlast on the final
// beat, padding bytes of the final beat driven 0. Data comes from LANE_NO LFSR lanes;
// a rotating valid_mask gates when new beats may be raised.
//   ap_clk, ap_rstn   : clock, synchronous active-low reset
//   start             : single-cycle run request (ignored unless idle)
//   vec_total, seed,
//   valid_mask        : run configuration, sampled on start
//   M_AXIS_*          : AXI4-Stream master
//   busy, done        : run in progress / one-cycle completion pulse
//   beat_cnt          : beats accepted in the current or last run
// Optional: define FP_GEN_TKEEP_EN to add M_AXIS_tkeep.
module fp_axis_vec_gen
    import fp_gen_pkg::*;
#(
    parameter int unsigned BUS_WIDTH          = 128,
    parameter int unsigned VECTOR_WIDTH_BYTES = 115,
    parameter int unsigned MAX_VEC_NO         = 1024,
    parameter int unsigned MASK_WIDTH         = 4
) (
    input  logic                              ap_clk,
    input  logic                              ap_rstn,
    input  logic                              start,
    input  logic [$clog2(MAX_VEC_NO+1)-1:0]   vec_total,
    input  logic [31:0]                       seed,
    input  logic [MASK_WIDTH-1:0]             valid_mask,
    output logic [BUS_WIDTH-1:0]              M_AXIS_tdata,
    output logic                              M_AXIS_tvalid,
    output logic                              M_AXIS_tlast,
`ifdef FP_GEN_TKEEP_EN
    output logic [BUS_WIDTH/8-1:0]            M_AXIS_tkeep,
`endif
    input  logic                              M_AXIS_tready,
    output logic                              busy,
    output logic                              done,
    output logic [31:0]                       beat_cnt
);

    localparam int unsigned LANE_NO   = BUS_WIDTH / 32;
    localparam int unsigned BUS_BYTES = BUS_WIDTH / 8;
    localparam int unsigned VT_W      = $clog2(MAX_VEC_NO + 1);
    localparam int unsigned BL_W      = $clog2(MAX_VEC_NO * VECTOR_WIDTH_BYTES + 1);
    localparam logic [BL_W-1:0] BB    = BL_W'(BUS_BYTES);

    state_t                r_state;
    state_t                w_state_d;
    logic [VT_W-1:0]       r_vec_total;
    logic [31:0]           r_seed;
    logic [MASK_WIDTH-1:0] r_mask;
    logic [BL_W-1:0]       r_bytes_left;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [BUS_WIDTH-1:0]  r_tdata;
    logic [31:0]           r_beat_cnt;
`ifdef FP_GEN_TKEEP_EN
    logic [BUS_BYTES-1:0]  r_tkeep;
`endif

    logic                  w_hs;
    logic                  w_raise;
    logic                  w_raise_last;
    logic                  w_load;
    logic [BL_W-1:0]       w_bytes_eff;
    logic [BUS_BYTES-1:0]  w_keep;
    logic [BUS_WIDTH-1:0]  w_lfsr_data;
    logic [BUS_WIDTH-1:0]  w_beat_masked;

    assign w_hs   = r_tvalid & M_AXIS_tready;
    assign w_load = (r_state == StLoad);

    // A new beat may follow a handshake in the same cycle, so byte accounting for
    // the new beat must see the post-handshake byte count.
    always_comb begin
        w_bytes_eff = r_bytes_left;
        if (w_hs) begin
            w_bytes_eff = (r_bytes_left > BB) ? (r_bytes_left - BB) : '0;
        end
        w_raise      = (r_state == StRun) && r_mask[0] &&
                       (!r_tvalid || (w_hs && !r_tlast));
        w_raise_last = (w_bytes_eff <= BB);
    end

    always_comb begin
        w_keep        = '0;
        w_beat_masked = '0;
        for (int j = 0; j < int'(BUS_BYTES); j++) begin
            w_keep[j] = !w_raise_last || (BL_W'(j) < w_bytes_eff);
            w_beat_masked[8*j +: 8] = w_keep[j] ? w_lfsr_data[8*j +: 8] : 8'h00;
        end
    end

    for (genvar i = 0; i < int'(LANE_NO); i++) begin : g_lane
        logic [31:0] w_seed_raw;
        logic [31:0] w_lane_seed;

        // An all-zero seed would lock the LFSR, so it is replaced by 1.
        assign w_seed_raw  = r_seed ^ (32'(i) * LANE_SEED_K);
        assign w_lane_seed = (w_seed_raw == 32'h0) ? 32'h1 : w_seed_raw;

        fp_lfsr32 u_lfsr (
            .i_clk  (ap_clk),
            .i_rstn (ap_rstn),
            .i_load (w_load),
            .i_seed (w_lane_seed),
            .i_en   (w_raise),
            .o_next (w_lfsr_data[32*i +: 32])
        );
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (start) w_state_d = StLoad;
            StLoad: w_state_d = (r_vec_total == '0) ? StFin : StRun;
            StRun:  if (w_hs && r_tlast) w_state_d = StFin;
            StFin:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rstn) begin
            r_state      <= StIdle;
            r_vec_total  <= '0;
            r_seed       <= '0;
            r_mask       <= '0;
            r_bytes_left <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tdata      <= '0;
            r_beat_cnt   <= '0;
        end else begin
            r_state <= w_state_d;

            if (r_state == StIdle && start) begin
                r_vec_total <= vec_total;
                r_seed      <= seed;
                r_mask      <= valid_mask;
                r_beat_cnt  <= '0;
            end

            if (r_state == StRun) begin
                r_mask <= {r_mask[0], r_mask[MASK_WIDTH-1:1]};
            end

            if (r_state == StLoad) begin
                r_bytes_left <= BL_W'(32'(r_vec_total) * 32'(VECTOR_WIDTH_BYTES));
            end else if (w_hs) begin
                r_bytes_left <= w_bytes_eff;
            end

            if (w_hs) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end

            if (w_raise) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_beat_masked;
                r_tlast  <= w_raise_last;
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end

`ifdef FP_GEN_TKEEP_EN
    always_ff @(posedge ap_clk) begin
        if (!ap_rstn) begin
            r_tkeep <= '0;
        end else if (w_raise) begin
            r_tkeep <= w_keep;
        end
    end

    assign M_AXIS_tkeep = r_tkeep;
`endif

    assign M_AXIS_tdata  = r_tdata;
    assign M_AXIS_tvalid = r_tvalid;
    assign M_AXIS_tlast  = r_tlast;
    assign busy          = (r_state == StLoad) || (r_state == StRun);
    assign done          = (r_state == StFin);
    assign beat_cnt      = r_beat_cnt;

endmodule
